// File: rtl/decode_stage_hs.sv
// RV32I/RV64I decode stage with valid/ready handshake and a single output register.
// Optional M-extension decode, load-use interlock bubble and synchronous flush.
module decode_stage_hs #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PC_W        = 32,
    parameter bit          ENABLE_M    = 1'b0,
    parameter bit          LOAD_USE_IL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    input  logic            in_kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [3:0]      out_op_class,
    output logic [2:0]      out_funct3,
    output logic            out_alt,
    output logic [4:0]      out_rs1_addr,
    output logic [4:0]      out_rs2_addr,
    output logic            out_rs1_en,
    output logic            out_rs2_en,
    output logic [4:0]      out_rd_addr,
    output logic            out_rd_en,
    output logic [XLEN-1:0] out_imm,
    output logic            out_kill,
    output logic            out_illegal
);

    typedef enum logic [3:0] {
        CLS_NONE    = 4'd0,
        CLS_ALU_REG = 4'd1,
        CLS_ALU_IMM = 4'd2,
        CLS_LUI     = 4'd3,
        CLS_AUIPC   = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_BRANCH  = 4'd7,
        CLS_LOAD    = 4'd8,
        CLS_STORE   = 4'd9,
        CLS_MULDIV  = 4'd10,
        CLS_FENCE   = 4'd11,
        CLS_ILLEGAL = 4'd15
    } op_class_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // Instruction fields
    logic [6:0] w_opcode;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = in_inst[6:0];
    assign w_rd     = in_inst[11:7];
    assign w_funct3 = in_inst[14:12];
    assign w_rs1    = in_inst[19:15];
    assign w_rs2    = in_inst[24:20];
    assign w_funct7 = in_inst[31:25];

    // Raw decode (before kill/illegal squashing)
    op_class_e   w_cls;
    logic        w_alt;
    logic        w_rs1_use;
    logic        w_rs2_use;
    logic        w_rd_use;
    logic [31:0] w_imm32;
    logic        w_shl_ok;
    logic        w_sra_ok;

    // RV64 widens shamt to 6 bits, leaving only inst[31:26] as the function field
    always_comb begin
        if (XLEN == 64) begin
            w_shl_ok = (in_inst[31:26] == 6'b000000);
            w_sra_ok = (in_inst[31:26] == 6'b010000);
        end else begin
            w_shl_ok = (in_inst[31:25] == 7'b0000000);
            w_sra_ok = (in_inst[31:25] == 7'b0100000);
        end
    end

    always_comb begin
        w_cls     = CLS_ILLEGAL;
        w_alt     = 1'b0;
        w_rs1_use = 1'b0;
        w_rs2_use = 1'b0;
        w_rd_use  = 1'b0;
        w_imm32   = '0;
        case (w_opcode)
            OPC_OP: begin
                w_rs1_use = 1'b1;
                w_rs2_use = 1'b1;
                w_rd_use  = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    w_cls = CLS_ALU_REG;
                end else if (w_funct7 == 7'b0100000 &&
                             (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
                    w_cls = CLS_ALU_REG;
                    w_alt = 1'b1;
                end else if (w_funct7 == 7'b0000001 && ENABLE_M) begin
                    w_cls = CLS_MULDIV;
                end
            end
            OPC_OP_IMM: begin
                w_rs1_use = 1'b1;
                w_rd_use  = 1'b1;
                w_imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
                case (w_funct3)
                    3'b001: begin
                        if (w_shl_ok) w_cls = CLS_ALU_IMM;
                    end
                    3'b101: begin
                        if (w_shl_ok) begin
                            w_cls = CLS_ALU_IMM;
                        end else if (w_sra_ok) begin
                            w_cls = CLS_ALU_IMM;
                            w_alt = 1'b1;
                        end
                    end
                    default: w_cls = CLS_ALU_IMM;
                endcase
            end
            OPC_LUI: begin
                w_cls    = CLS_LUI;
                w_rd_use = 1'b1;
                w_imm32  = {in_inst[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                w_cls    = CLS_AUIPC;
                w_rd_use = 1'b1;
                w_imm32  = {in_inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                w_cls    = CLS_JAL;
                w_rd_use = 1'b1;
                w_imm32  = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20],
                            in_inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                if (w_funct3 == 3'b000) w_cls = CLS_JALR;
                w_rs1_use = 1'b1;
                w_rd_use  = 1'b1;
                w_imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OPC_BRANCH: begin
                if (w_funct3 != 3'b010 && w_funct3 != 3'b011) w_cls = CLS_BRANCH;
                w_rs1_use = 1'b1;
                w_rs2_use = 1'b1;
                w_imm32   = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25],
                             in_inst[11:8], 1'b0};
            end
            OPC_LOAD: begin
                if (w_funct3 == 3'b000 || w_funct3 == 3'b001 || w_funct3 == 3'b010 ||
                    w_funct3 == 3'b100 || w_funct3 == 3'b101 ||
                    (XLEN == 64 && (w_funct3 == 3'b011 || w_funct3 == 3'b110)))
                    w_cls = CLS_LOAD;
                w_rs1_use = 1'b1;
                w_rd_use  = 1'b1;
                w_imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OPC_STORE: begin
                if (w_funct3 == 3'b000 || w_funct3 == 3'b001 || w_funct3 == 3'b010 ||
                    (XLEN == 64 && w_funct3 == 3'b011))
                    w_cls = CLS_STORE;
                w_rs1_use = 1'b1;
                w_rs2_use = 1'b1;
                w_imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OPC_FENCE: begin
                if (w_funct3 == 3'b000) w_cls = CLS_FENCE;
                w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            default: w_cls = CLS_ILLEGAL;
        endcase
    end

    logic [XLEN-1:0] w_imm_ext;

    if (XLEN > 32) begin : g_imm_sext
        assign w_imm_ext = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_imm_direct
        assign w_imm_ext = w_imm32[XLEN-1:0];
    end

    // Final bundle: kill and illegal both clear every enable and the immediate
    logic            w_squash;
    op_class_e       w_cls_fin;
    logic            w_alt_fin;
    logic            w_rs1_en;
    logic            w_rs2_en;
    logic            w_rd_en;
    logic [4:0]      w_rs1_addr;
    logic [4:0]      w_rs2_addr;
    logic [4:0]      w_rd_addr;
    logic [XLEN-1:0] w_imm;

    assign w_squash   = in_kill || (w_cls == CLS_ILLEGAL);
    assign w_cls_fin  = in_kill ? CLS_NONE : w_cls;
    assign w_alt_fin  = !w_squash && w_alt;
    assign w_rs1_en   = !w_squash && w_rs1_use;
    assign w_rs2_en   = !w_squash && w_rs2_use;
    assign w_rd_en    = !w_squash && w_rd_use && (w_rd != 5'd0);
    assign w_rs1_addr = w_rs1_en ? w_rs1 : '0;
    assign w_rs2_addr = w_rs2_en ? w_rs2 : '0;
    assign w_rd_addr  = w_rd_en ? w_rd : '0;
    assign w_imm      = w_squash ? '0 : w_imm_ext;

    // Output register
    logic            r_valid;
    logic [PC_W-1:0] r_pc;
    op_class_e       r_op;
    logic [2:0]      r_funct3;
    logic            r_alt;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic            r_rs1_en;
    logic            r_rs2_en;
    logic [4:0]      r_rd;
    logic            r_rd_en;
    logic [XLEN-1:0] r_imm;
    logic            r_kill;

    logic w_il_stall;
    logic w_xfer;

    // Load-use hazard: incoming instruction reads the load's destination
    assign w_il_stall = LOAD_USE_IL && r_valid && (r_op == CLS_LOAD) && r_rd_en && in_valid &&
                        ((w_rs1_en && (w_rs1_addr == r_rd)) ||
                         (w_rs2_en && (w_rs2_addr == r_rd)));

    assign in_ready = !reset && !flush && (!r_valid || out_ready) && !w_il_stall;
    assign w_xfer   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= 1'b0;
            r_pc     <= '0;
            r_op     <= CLS_NONE;
            r_funct3 <= '0;
            r_alt    <= 1'b0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rs1_en <= 1'b0;
            r_rs2_en <= 1'b0;
            r_rd     <= '0;
            r_rd_en  <= 1'b0;
            r_imm    <= '0;
            r_kill   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_valid  <= 1'b1;
            r_pc     <= in_pc;
            r_op     <= w_cls_fin;
            r_funct3 <= w_funct3;
            r_alt    <= w_alt_fin;
            r_rs1    <= w_rs1_addr;
            r_rs2    <= w_rs2_addr;
            r_rs1_en <= w_rs1_en;
            r_rs2_en <= w_rs2_en;
            r_rd     <= w_rd_addr;
            r_rd_en  <= w_rd_en;
            r_imm    <= w_imm;
            r_kill   <= in_kill;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_op_class = r_op;
    assign out_funct3   = r_funct3;
    assign out_alt      = r_alt;
    assign out_rs1_addr = r_rs1;
    assign out_rs2_addr = r_rs2;
    assign out_rs1_en   = r_rs1_en;
    assign out_rs2_en   = r_rs2_en;
    assign out_rd_addr  = r_rd;
    assign out_rd_en    = r_rd_en;
    assign out_imm      = r_imm;
    assign out_kill     = r_kill;
    assign out_illegal  = (r_op == CLS_ILLEGAL);

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: default, M-enabled, no-interlock and RV64 instances.
module tb_decode_stage_hs;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, nil_in_valid, in_kill, out_ready;
    logic [31:0] in_inst, in_pc;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    // Default instance (m_)
    logic m_in_ready, m_out_valid, m_alt, m_rs1_en, m_rs2_en, m_rd_en, m_kill, m_illegal;
    logic [31:0] m_pc, m_imm;
    logic [3:0]  m_cls;
    logic [2:0]  m_f3;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    // ENABLE_M=1 instance (e_)
    logic e_in_ready, e_out_valid, e_alt, e_rs1_en, e_rs2_en, e_rd_en, e_kill, e_illegal;
    logic [31:0] e_pc, e_imm;
    logic [3:0]  e_cls;
    logic [2:0]  e_f3;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    // LOAD_USE_IL=0 instance (n_)
    logic n_in_ready, n_out_valid, n_alt, n_rs1_en, n_rs2_en, n_rd_en, n_kill, n_illegal;
    logic [31:0] n_pc, n_imm;
    logic [3:0]  n_cls;
    logic [2:0]  n_f3;
    logic [4:0]  n_rs1, n_rs2, n_rd;
    // XLEN=64 instance (x_)
    logic x_in_ready, x_out_valid, x_alt, x_rs1_en, x_rs2_en, x_rd_en, x_kill, x_illegal;
    logic [31:0] x_pc;
    logic [63:0] x_imm;
    logic [3:0]  x_cls;
    logic [2:0]  x_f3;
    logic [4:0]  x_rs1, x_rs2, x_rd;

    decode_stage_hs u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_kill(in_kill), .out_valid(m_out_valid),
        .out_ready(out_ready), .out_pc(m_pc), .out_op_class(m_cls), .out_funct3(m_f3),
        .out_alt(m_alt), .out_rs1_addr(m_rs1), .out_rs2_addr(m_rs2), .out_rs1_en(m_rs1_en),
        .out_rs2_en(m_rs2_en), .out_rd_addr(m_rd), .out_rd_en(m_rd_en), .out_imm(m_imm),
        .out_kill(m_kill), .out_illegal(m_illegal));

    decode_stage_hs #(.ENABLE_M(1'b1)) u_dut_m (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(e_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_kill(in_kill), .out_valid(e_out_valid),
        .out_ready(out_ready), .out_pc(e_pc), .out_op_class(e_cls), .out_funct3(e_f3),
        .out_alt(e_alt), .out_rs1_addr(e_rs1), .out_rs2_addr(e_rs2), .out_rs1_en(e_rs1_en),
        .out_rs2_en(e_rs2_en), .out_rd_addr(e_rd), .out_rd_en(e_rd_en), .out_imm(e_imm),
        .out_kill(e_kill), .out_illegal(e_illegal));

    decode_stage_hs #(.LOAD_USE_IL(1'b0)) u_dut_nil (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(nil_in_valid), .in_ready(n_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_kill(in_kill), .out_valid(n_out_valid),
        .out_ready(out_ready), .out_pc(n_pc), .out_op_class(n_cls), .out_funct3(n_f3),
        .out_alt(n_alt), .out_rs1_addr(n_rs1), .out_rs2_addr(n_rs2), .out_rs1_en(n_rs1_en),
        .out_rs2_en(n_rs2_en), .out_rd_addr(n_rd), .out_rd_en(n_rd_en), .out_imm(n_imm),
        .out_kill(n_kill), .out_illegal(n_illegal));

    decode_stage_hs #(.XLEN(64)) u_dut_64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(x_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .in_kill(in_kill), .out_valid(x_out_valid),
        .out_ready(out_ready), .out_pc(x_pc), .out_op_class(x_cls), .out_funct3(x_f3),
        .out_alt(x_alt), .out_rs1_addr(x_rs1), .out_rs2_addr(x_rs2), .out_rs1_en(x_rs1_en),
        .out_rs2_en(x_rs2_en), .out_rd_addr(x_rd), .out_rd_en(x_rd_en), .out_imm(x_imm),
        .out_kill(x_kill), .out_illegal(x_illegal));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single edge with out_ready=1, then withdraw it
    task automatic present(input logic [31:0] inst, input logic [31:0] pc);
        in_inst   = inst;
        in_pc     = pc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_kill = 1'b0; nil_in_valid = 1'b0;
        in_valid = 1'b1; in_inst = 32'hFFB10093; in_pc = 32'h40; out_ready = 1'b1;
        tick(); tick();
        n_tests++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", m_out_valid); end
        n_tests++; if (m_cls !== 4'd0) begin n_fail++; $display("FAIL reset_class got %0d exp 0", m_cls); end
        n_tests++; if (m_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", m_in_ready); end
        n_tests++; if (m_imm !== 32'h0 || m_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_regs got imm=%h rd_en=%b exp 0/0", m_imm, m_rd_en); end
        reset = 1'b0; in_valid = 1'b0;
        tick();
        n_tests++; if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b exp 1", m_in_ready); end
    endtask

    task automatic test_addi();
        in_inst = 32'hFFB10093; in_pc = 32'h100; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_tests++; if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL addi_in_ready got %b exp 1", m_in_ready); end
        tick(); in_valid = 1'b0;
        n_tests++; if (m_out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b exp 1", m_out_valid); end
        n_tests++; if (m_cls !== 4'd2) begin n_fail++; $display("FAIL addi_class got %0d exp 2", m_cls); end
        n_tests++; if (m_rs1 !== 5'd2 || m_rs1_en !== 1'b1 || m_rs2_en !== 1'b0) begin n_fail++; $display("FAIL addi_rs got rs1=%0d en1=%b en2=%b exp 2/1/0", m_rs1, m_rs1_en, m_rs2_en); end
        n_tests++; if (m_rd !== 5'd1 || m_rd_en !== 1'b1) begin n_fail++; $display("FAIL addi_rd got rd=%0d en=%b exp 1/1", m_rd, m_rd_en); end
        n_tests++; if (m_imm !== 32'hFFFFFFFB) begin n_fail++; $display("FAIL addi_imm got %h exp fffffffb", m_imm); end
        n_tests++; if (m_pc !== 32'h100 || m_f3 !== 3'd0) begin n_fail++; $display("FAIL addi_pc_f3 got %h/%0d exp 100/0", m_pc, m_f3); end
        n_tests++; if (x_imm !== 64'hFFFFFFFFFFFFFFFB) begin n_fail++; $display("FAIL addi_imm64 got %h exp fffffffffffffffb", x_imm); end
        tick();
        n_tests++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain got %b exp 0", m_out_valid); end
    endtask

    task automatic test_hold();
        in_inst = 32'h00700193; in_pc = 32'h200; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_inst = 32'h00728333; in_pc = 32'h204;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++; if (m_in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d] got %b exp 0", i, m_in_ready); end
            tick();
            n_tests++; if (m_out_valid !== 1'b1 || m_rd !== 5'd3 || m_imm !== 32'h7 || m_pc !== 32'h200) begin
                n_fail++; $display("FAIL hold_stable[%0d] got v=%b rd=%0d imm=%h pc=%h exp 1/3/7/200", i, m_out_valid, m_rd, m_imm, m_pc); end
        end
        out_ready = 1'b1;
        #1;
        n_tests++; if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready got %b exp 1", m_in_ready); end
        tick(); in_valid = 1'b0;
        n_tests++; if (m_out_valid !== 1'b1 || m_cls !== 4'd1 || m_pc !== 32'h204) begin n_fail++; $display("FAIL hold_next got v=%b cls=%0d pc=%h exp 1/1/204", m_out_valid, m_cls, m_pc); end
        n_tests++; if (m_rs1 !== 5'd5 || m_rs2 !== 5'd7 || m_rd !== 5'd6 || m_imm !== 32'h0) begin n_fail++; $display("FAIL hold_add_fields got %0d/%0d/%0d imm=%h exp 5/7/6/0", m_rs1, m_rs2, m_rd, m_imm); end
        drain();
    endtask

    task automatic test_load_use();
        present(32'h0000A283, 32'h300);
        n_tests++; if (m_cls !== 4'd8 || m_rd !== 5'd5 || m_rd_en !== 1'b1 || m_rs1 !== 5'd1) begin n_fail++; $display("FAIL lw_decode got cls=%0d rd=%0d en=%b rs1=%0d exp 8/5/1/1", m_cls, m_rd, m_rd_en, m_rs1); end
        in_inst = 32'h00728333; in_pc = 32'h304; in_valid = 1'b1;
        #1;
        n_tests++; if (m_in_ready !== 1'b0) begin n_fail++; $display("FAIL lu_stall_ready got %b exp 0", m_in_ready); end
        tick();
        n_tests++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got %b exp 0", m_out_valid); end
        n_tests++; if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_accept_ready got %b exp 1", m_in_ready); end
        tick(); in_valid = 1'b0;
        n_tests++; if (m_out_valid !== 1'b1 || m_pc !== 32'h304 || m_cls !== 4'd1) begin n_fail++; $display("FAIL lu_add_out got v=%b pc=%h cls=%0d exp 1/304/1", m_out_valid, m_pc, m_cls); end
        drain();
        // Independent consumer after a load must not stall
        present(32'h0000A283, 32'h310);
        in_inst = 32'h00720333; in_pc = 32'h314; in_valid = 1'b1;
        #1;
        n_tests++; if (m_in_ready !== 1'b1) begin n_fail++; $display("FAIL lu_nodep_ready got %b exp 1", m_in_ready); end
        tick(); in_valid = 1'b0;
        drain();
        // No-interlock instance: back-to-back
        in_inst = 32'h0000A283; in_pc = 32'h320; nil_in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_inst = 32'h00728333; in_pc = 32'h324;
        #1;
        n_tests++; if (n_in_ready !== 1'b1) begin n_fail++; $display("FAIL nil_ready got %b exp 1", n_in_ready); end
        tick(); nil_in_valid = 1'b0;
        n_tests++; if (n_out_valid !== 1'b1 || n_pc !== 32'h324 || n_cls !== 4'd1) begin n_fail++; $display("FAIL nil_b2b got v=%b pc=%h cls=%0d exp 1/324/1", n_out_valid, n_pc, n_cls); end
        drain();
    endtask

    task automatic test_flush();
        present(32'h00700193, 32'h400);
        in_inst = 32'h00728333; in_pc = 32'h404; in_valid = 1'b1; flush = 1'b1;
        #1;
        n_tests++; if (m_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b exp 0", m_in_ready); end
        tick();
        n_tests++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", m_out_valid); end
        flush = 1'b0; in_valid = 1'b0;
        tick();
        n_tests++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got %b exp 0", m_out_valid); end
        // Flush beats hold
        in_inst = 32'h00700193; in_pc = 32'h408; in_valid = 1'b1; out_ready = 1'b0;
        tick(); in_valid = 1'b0; flush = 1'b1;
        tick(); flush = 1'b0;
        n_tests++; if (m_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_hold got %b exp 0", m_out_valid); end
        drain();
    endtask

    task automatic test_decode();
        present(32'h00000000, 32'h500);
        n_tests++; if (m_out_valid !== 1'b1 || m_cls !== 4'd15 || m_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_zero got v=%b cls=%0d ill=%b exp 1/15/1", m_out_valid, m_cls, m_illegal); end
        n_tests++; if (m_rd_en !== 1'b0 || m_rs1_en !== 1'b0 || m_imm !== 32'h0) begin n_fail++; $display("FAIL ill_zero_en got rd_en=%b rs1_en=%b imm=%h exp 0/0/0", m_rd_en, m_rs1_en, m_imm); end
        present(32'h02208033, 32'h504);
        n_tests++; if (m_cls !== 4'd15) begin n_fail++; $display("FAIL mul_nom got %0d exp 15", m_cls); end
        n_tests++; if (e_cls !== 4'd10 || e_rs1 !== 5'd1 || e_rs2 !== 5'd2 || e_rd_en !== 1'b0) begin n_fail++; $display("FAIL mul_m got cls=%0d rs1=%0d rs2=%0d rd_en=%b exp 10/1/2/0", e_cls, e_rs1, e_rs2, e_rd_en); end
        present(32'hFFDFF0EF, 32'h508);
        n_tests++; if (m_cls !== 4'd5 || m_imm !== 32'hFFFFFFFC || m_rd !== 5'd1 || m_rs1_en !== 1'b0) begin n_fail++; $display("FAIL jal got cls=%0d imm=%h rd=%0d rs1_en=%b exp 5/fffffffc/1/0", m_cls, m_imm, m_rd, m_rs1_en); end
        n_tests++; if (x_imm !== 64'hFFFFFFFFFFFFFFFC) begin n_fail++; $display("FAIL jal64 got %h exp fffffffffffffffc", x_imm); end
        in_kill = 1'b1;
        present(32'hFFB10093, 32'h50C);
        in_kill = 1'b0;
        n_tests++; if (m_cls !== 4'd0 || m_kill !== 1'b1 || m_illegal !== 1'b0 || m_out_valid !== 1'b1) begin n_fail++; $display("FAIL kill got cls=%0d kill=%b ill=%b v=%b exp 0/1/0/1", m_cls, m_kill, m_illegal, m_out_valid); end
        n_tests++; if (m_rd_en !== 1'b0 || m_rs1_en !== 1'b0 || m_imm !== 32'h0) begin n_fail++; $display("FAIL kill_en got rd_en=%b rs1_en=%b imm=%h exp 0/0/0", m_rd_en, m_rs1_en, m_imm); end
        present(32'h40315093, 32'h510);
        n_tests++; if (m_cls !== 4'd2 || m_alt !== 1'b1 || m_f3 !== 3'd5) begin n_fail++; $display("FAIL srai got cls=%0d alt=%b f3=%0d exp 2/1/5", m_cls, m_alt, m_f3); end
        present(32'h40311093, 32'h514);
        n_tests++; if (m_cls !== 4'd15 || x_cls !== 4'd15) begin n_fail++; $display("FAIL slli_badf7 got %0d/%0d exp 15/15", m_cls, x_cls); end
        present(32'h02011093, 32'h518);
        n_tests++; if (m_cls !== 4'd15) begin n_fail++; $display("FAIL slli32_rv32 got %0d exp 15", m_cls); end
        n_tests++; if (x_cls !== 4'd2 || x_imm !== 64'h20) begin n_fail++; $display("FAIL slli32_rv64 got cls=%0d imm=%h exp 2/20", x_cls, x_imm); end
        present(32'h00208463, 32'h51C);
        n_tests++; if (m_cls !== 4'd7 || m_rs1_en !== 1'b1 || m_rs2_en !== 1'b1 || m_rs2 !== 5'd2 || m_rd_en !== 1'b0 || m_imm !== 32'h8) begin
            n_fail++; $display("FAIL beq got cls=%0d en=%b%b rs2=%0d rd_en=%b imm=%h exp 7/11/2/0/8", m_cls, m_rs1_en, m_rs2_en, m_rs2, m_rd_en, m_imm); end
        drain();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_hold();
        test_load_use();
        test_flush();
        test_decode();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
